bus8_master: RTL and testbench
==============================

# bus8_master

Bus8 initiator: accepts write/read commands from local logic, queues them in a small FIFO and executes them one at a time on the Bus8 register bus (CS / Wr_Rd_n / Addr8 / Wr_Data out, Rd_Data / Rd_DV back). Reads return the data on a response port, or a timeout flag if no register block answers. It is the synthesizable counterpart of the register responders (e.g. Bus8 register banks) and replaces the simulation-only bus driver when firmware-less control (a UART or command decoder) must reach the register map.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 16, max cycles in WAIT_RD before a read is abandoned (≥1)

Ports:
- i_Bus_Clk  in  1  single clock; one clock, all logic on its rising edge
- i_Bus_Rst_L  in  1  reset, asynchronous, active-low
- i_Cmd_DV  in  1  command strobe; accepted when i_Cmd_DV & o_Cmd_Ready at an edge
- i_Cmd_Wr_Rd_n  in  1  1 = write, 0 = read
- i_Cmd_Addr  in  8  register address
- i_Cmd_Data  in  8  write data (ignored for reads)
- o_Cmd_Ready  out  1  FIFO not full
- o_Rsp_DV  out  1  one-cycle pulse per completed read
- o_Rsp_Data  out  8  read data, valid with o_Rsp_DV
- o_Rsp_Timeout  out  1  valid with o_Rsp_DV; 1 = no Rd_DV received
- o_Busy  out  1  FIFO non-empty or state ≠ IDLE
- o_Bus_CS  out  1  one-cycle transaction strobe
- o_Bus_Wr_Rd_n  out  1  direction of current transaction
- o_Bus_Addr8  out  8  address of current transaction
- o_Bus_Wr_Data  out  8  write data; 0x00 for reads
- i_Bus_Rd_Data  in  8  responder read data
- i_Bus_Rd_DV  in  1  responder read-data valid

## Operation
- Command FIFO: 17 bits/entry (Wr_Rd_n, Addr, Data). o_Cmd_Ready = !full from current count (a same-cycle pop does not free a slot for that edge's push). i_Cmd_DV while !o_Cmd_Ready: command dropped, no state change. Simultaneous push+pop: count unchanged. Order strictly preserved.
- FSM states IDLE, ISSUE, WAIT_RD:
  - IDLE: if FIFO non-empty: pop, load o_Bus_Addr8/o_Bus_Wr_Rd_n/o_Bus_Wr_Data, o_Bus_CS←1, go ISSUE.
  - ISSUE: o_Bus_CS←0. Write → IDLE. Read → WAIT_RD, timeout counter←0.
  - WAIT_RD: i_Bus_Rd_DV=1 → o_Rsp_Data←i_Bus_Rd_Data, o_Rsp_Timeout←0, o_Rsp_DV←1, go IDLE. Else counter+1; on the TIMEOUT-th WAIT_RD edge without DV → o_Rsp_Data←0x00, o_Rsp_Timeout←1, o_Rsp_DV←1, go IDLE. DV on the final allowed edge wins over timeout.
- i_Bus_Rd_DV outside WAIT_RD ignored (late/stray responses dropped).
- Writes produce no response. One outstanding transaction at a time.
- o_Bus_Addr8/o_Bus_Wr_Rd_n/o_Bus_Wr_Data hold last values until the next pop.
- Counter width $clog2(TIMEOUT+1); no wrap possible.

## Timing
- Reset (async assert, sync-safe release): state IDLE, FIFO empty, counter 0; o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data, o_Rsp_DV, o_Rsp_Data, o_Rsp_Timeout, o_Busy = 0; o_Cmd_Ready = 1.
- Reset mid-transaction: transaction abandoned, no o_Rsp_DV, queued commands lost.
- Command accepted at edge E into empty FIFO while IDLE → o_Bus_CS high for exactly the cycle after edge E+1.
- Back-to-back commands: CS pulses at minimum 2-cycle spacing (ISSUE→IDLE→pop).
- Read: o_Rsp_DV high the cycle after the edge sampling i_Bus_Rd_DV=1; timeout response the cycle after the TIMEOUT-th WAIT_RD edge.
- o_Rsp_DV never high two consecutive cycles.

## Test plan
- Reset: hold i_Bus_Rst_L=0 10 cycles → all outputs 0, o_Cmd_Ready=1, o_Busy=0; release, no CS.
- Write {addr 0x01, data 0x7B} → single CS pulse, Wr_Rd_n=1, Addr8=0x01, Wr_Data=0x7B, after edge E+1; no o_Rsp_DV; o_Busy back to 0.
- Read 0x02 with responder model returning 0x55 one cycle after CS → one o_Rsp_DV pulse, Rsp_Data=0x55, Rsp_Timeout=0; CS-Wr_Data=0x00.
- Read 0x03, responder silent, TIMEOUT=16 → o_Rsp_DV with Rsp_Data=0x00, Rsp_Timeout=1 after 16 WAIT_RD cycles; Rd_DV injected 3 cycles later ignored; variant with DV on 16th cycle → data returned, Timeout=0.
- Stall first read (responder delays 20 cycles), push 6 commands consecutively → o_Cmd_Ready=0 once 4 queued, extra commands dropped, accepted ones issued in push order.
- Assert reset during WAIT_RD with 2 commands queued → no o_Rsp_DV, o_Busy=0, o_Cmd_Ready=1, no further CS after release.

Source files
------------

// File: rtl/bus8_master.sv
// Bus8 initiator: queues local write/read commands and runs them one at a time on the Bus8
// register bus, returning read data (or a timeout flag) on the response port.
module bus8_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       i_Bus_Clk,
    input  logic       i_Bus_Rst_L,
    input  logic       i_Cmd_DV,
    input  logic       i_Cmd_Wr_Rd_n,
    input  logic [7:0] i_Cmd_Addr,
    input  logic [7:0] i_Cmd_Data,
    output logic       o_Cmd_Ready,
    output logic       o_Rsp_DV,
    output logic [7:0] o_Rsp_Data,
    output logic       o_Rsp_Timeout,
    output logic       o_Busy,
    output logic       o_Bus_CS,
    output logic       o_Bus_Wr_Rd_n,
    output logic [7:0] o_Bus_Addr8,
    output logic [7:0] o_Bus_Wr_Data,
    input  logic [7:0] i_Bus_Rd_Data,
    input  logic       i_Bus_Rd_DV
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd
    } state_e;

    state_e state_q, state_d;

    // Entry layout: {wr_rd_n, addr[7:0], data[7:0]}
    logic [16:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [16:0]      head;
    logic             fifo_empty;
    logic             push, pop;

    logic             bus_cs_q, bus_cs_d;
    logic             bus_wr_rd_n_q, bus_wr_rd_n_d;
    logic [7:0]       bus_addr_q, bus_addr_d;
    logic [7:0]       bus_wr_data_q, bus_wr_data_d;
    logic             rsp_dv_q, rsp_dv_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign fifo_empty  = (cnt_q == '0);
    assign o_Cmd_Ready = (cnt_q != FULL_CNT);
    assign push        = i_Cmd_DV & o_Cmd_Ready;
    assign head        = fifo_mem[rd_ptr_q];

    always_ff @(posedge i_Bus_Clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {i_Cmd_Wr_Rd_n, i_Cmd_Addr, i_Cmd_Data};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        bus_cs_d      = 1'b0;
        bus_wr_rd_n_d = bus_wr_rd_n_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rsp_dv_d      = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    bus_cs_d      = 1'b1;
                    bus_wr_rd_n_d = head[16];
                    bus_addr_d    = head[15:8];
                    bus_wr_data_d = head[16] ? head[7:0] : 8'h00;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (bus_wr_rd_n_q) begin
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = StWaitRd;
                end
            end
            StWaitRd: begin
                // A response on the last allowed edge still beats the timeout
                if (i_Bus_Rd_DV) begin
                    rsp_dv_d      = 1'b1;
                    rsp_data_d    = i_Bus_Rd_Data;
                    rsp_timeout_d = 1'b0;
                    state_d       = StIdle;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_dv_d      = 1'b1;
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            bus_cs_q      <= 1'b0;
            bus_wr_rd_n_q <= 1'b0;
            bus_addr_q    <= 8'h00;
            bus_wr_data_q <= 8'h00;
            rsp_dv_q      <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            bus_cs_q      <= bus_cs_d;
            bus_wr_rd_n_q <= bus_wr_rd_n_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rsp_dv_q      <= rsp_dv_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign o_Busy        = !fifo_empty || (state_q != StIdle);
    assign o_Bus_CS      = bus_cs_q;
    assign o_Bus_Wr_Rd_n = bus_wr_rd_n_q;
    assign o_Bus_Addr8   = bus_addr_q;
    assign o_Bus_Wr_Data = bus_wr_data_q;
    assign o_Rsp_DV      = rsp_dv_q;
    assign o_Rsp_Data    = rsp_data_q;
    assign o_Rsp_Timeout = rsp_timeout_q;

endmodule

// File: tb/tb_bus8_master.sv
// Bench for bus8_master: directed timing checks plus randomized command bursts scored against
// a transaction-level model (expected bus transactions and read responses as queues).
module tb_bus8_master;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TIMEOUT    = 16;

    logic       i_Bus_Clk = 1'b0;
    logic       i_Bus_Rst_L = 1'b0;
    logic       i_Cmd_DV = 1'b0;
    logic       i_Cmd_Wr_Rd_n = 1'b0;
    logic [7:0] i_Cmd_Addr = 8'h00;
    logic [7:0] i_Cmd_Data = 8'h00;
    logic [7:0] i_Bus_Rd_Data = 8'h00;
    logic       i_Bus_Rd_DV = 1'b0;
    logic       o_Cmd_Ready, o_Rsp_DV, o_Rsp_Timeout, o_Busy;
    logic       o_Bus_CS, o_Bus_Wr_Rd_n;
    logic [7:0] o_Rsp_Data, o_Bus_Addr8, o_Bus_Wr_Data;

    bus8_master #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_Bus_Clk    (i_Bus_Clk),
        .i_Bus_Rst_L  (i_Bus_Rst_L),
        .i_Cmd_DV     (i_Cmd_DV),
        .i_Cmd_Wr_Rd_n(i_Cmd_Wr_Rd_n),
        .i_Cmd_Addr   (i_Cmd_Addr),
        .i_Cmd_Data   (i_Cmd_Data),
        .o_Cmd_Ready  (o_Cmd_Ready),
        .o_Rsp_DV     (o_Rsp_DV),
        .o_Rsp_Data   (o_Rsp_Data),
        .o_Rsp_Timeout(o_Rsp_Timeout),
        .o_Busy       (o_Busy),
        .o_Bus_CS     (o_Bus_CS),
        .o_Bus_Wr_Rd_n(o_Bus_Wr_Rd_n),
        .o_Bus_Addr8  (o_Bus_Addr8),
        .o_Bus_Wr_Data(o_Bus_Wr_Data),
        .i_Bus_Rd_Data(i_Bus_Rd_Data),
        .i_Bus_Rd_DV  (i_Bus_Rd_DV)
    );

    initial forever #5 i_Bus_Clk = ~i_Bus_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: {wr_rd_n, addr, wr_data} and {timeout, data}
    logic [16:0] exp_bus[$];
    logic [16:0] obs_bus[$];
    logic [8:0]  exp_rsp[$];
    logic [8:0]  obs_rsp[$];
    // Responder plan per read, in issue order: DV delay in cycles after CS (0 = silent)
    int          plan_d[$];
    logic [7:0]  plan_data[$];
    logic [7:0]  due_map[int];
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    initial begin : monitor
        logic prev_cs;
        logic prev_rsp;
        prev_cs  = 1'b0;
        prev_rsp = 1'b0;
        forever begin
            @(negedge i_Bus_Clk);
            if (o_Bus_CS === 1'b1) begin
                obs_bus.push_back({o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data});
                check("cs_back_to_back", 32'(prev_cs), 32'(0));
            end
            if (o_Rsp_DV === 1'b1) begin
                obs_rsp.push_back({o_Rsp_Timeout, o_Rsp_Data});
                check("rsp_back_to_back", 32'(prev_rsp), 32'(0));
            end
            prev_cs  = o_Bus_CS;
            prev_rsp = o_Rsp_DV;
        end
    end

    initial begin : responder
        int         d;
        logic [7:0] dat;
        forever begin
            @(posedge i_Bus_Clk);
            #1;
            cyc++;
            if (o_Bus_CS === 1'b1 && o_Bus_Wr_Rd_n === 1'b0 && plan_d.size() > 0) begin
                d   = plan_d.pop_front();
                dat = plan_data.pop_front();
                if (d > 0) due_map[cyc + d] = dat;
            end
            if (due_map.exists(cyc)) begin
                i_Bus_Rd_DV   = 1'b1;
                i_Bus_Rd_Data = due_map[cyc];
                due_map.delete(cyc);
            end else begin
                i_Bus_Rd_DV   = 1'b0;
                i_Bus_Rd_Data = 8'($urandom);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_add(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                             input int d, input logic [7:0] rdata);
        bit tmo;
        exp_bus.push_back({wr, addr, wr ? data : 8'h00});
        if (!wr) begin
            tmo = !(d >= 1 && d <= int'(TIMEOUT));
            plan_d.push_back(d);
            plan_data.push_back(rdata);
            exp_rsp.push_back({tmo, tmo ? 8'h00 : rdata});
        end
    endtask

    // Called at a negedge; presents one command for the next rising edge.
    task automatic push_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            input int d, input logic [7:0] rdata, input bit exp_ready,
                            input bit keep);
        check("cmd_ready", 32'(o_Cmd_Ready), 32'(exp_ready));
        i_Cmd_DV      = 1'b1;
        i_Cmd_Wr_Rd_n = wr;
        i_Cmd_Addr    = addr;
        i_Cmd_Data    = data;
        if (exp_ready && keep) model_add(wr, addr, data, d, rdata);
        @(negedge i_Bus_Clk);
        i_Cmd_DV   = 1'b0;
        i_Cmd_Data = 8'($urandom);
    endtask

    task automatic settle_and_score(input string tag);
        int n;
        int m;
        n = 0;
        while (o_Busy === 1'b1 && n < 400) begin
            @(negedge i_Bus_Clk);
            n++;
        end
        check({tag, "_idle"}, 32'(o_Busy), 32'(0));
        repeat (TIMEOUT + 6) @(negedge i_Bus_Clk);
        check({tag, "_bus_count"}, 32'(obs_bus.size()), 32'(exp_bus.size()));
        m = (obs_bus.size() < exp_bus.size()) ? obs_bus.size() : exp_bus.size();
        for (int i = 0; i < m; i++) check({tag, "_bus_item"}, 32'(obs_bus[i]), 32'(exp_bus[i]));
        check({tag, "_rsp_count"}, 32'(obs_rsp.size()), 32'(exp_rsp.size()));
        m = (obs_rsp.size() < exp_rsp.size()) ? obs_rsp.size() : exp_rsp.size();
        for (int i = 0; i < m; i++) check({tag, "_rsp_item"}, 32'(obs_rsp[i]), 32'(exp_rsp[i]));
        obs_bus.delete();
        exp_bus.delete();
        obs_rsp.delete();
        exp_rsp.delete();
    endtask

    // Single read with exact response timing: DV sampled on WAIT_RD edge d, rsp the cycle after.
    task automatic read_timed(input string tag, input logic [7:0] addr, input int d,
                              input logic [7:0] rdata);
        bit tmo;
        int m;
        tmo = !(d >= 1 && d <= int'(TIMEOUT));
        m   = tmo ? int'(TIMEOUT) + 2 : d + 2;
        push_cmd(1'b0, addr, 8'hA5, d, rdata, 1'b1, 1'b1);
        @(negedge i_Bus_Clk);
        check({tag, "_cs"}, 32'(o_Bus_CS), 32'(1));
        check({tag, "_bus"}, 32'({o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data}),
              32'({1'b0, addr, 8'h00}));
        repeat (m - 2) @(negedge i_Bus_Clk);
        check({tag, "_rsp_early"}, 32'(o_Rsp_DV), 32'(0));
        @(negedge i_Bus_Clk);
        check({tag, "_rsp_dv"}, 32'(o_Rsp_DV), 32'(1));
        check({tag, "_rsp"}, 32'({o_Rsp_Timeout, o_Rsp_Data}),
              32'({tmo, tmo ? 8'h00 : rdata}));
        @(negedge i_Bus_Clk);
        check({tag, "_rsp_pulse"}, 32'(o_Rsp_DV), 32'(0));
        settle_and_score(tag);
    endtask

    initial begin : stimulus
        int         accepted;
        int         nb;
        logic       wr;
        logic [7:0] rnd_d;

        // Reset values
        repeat (10) @(negedge i_Bus_Clk);
        check("rst_bus", 32'({o_Bus_CS, o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data}), 32'(0));
        check("rst_rsp", 32'({o_Rsp_DV, o_Rsp_Timeout, o_Rsp_Data}), 32'(0));
        check("rst_busy", 32'(o_Busy), 32'(0));
        check("rst_ready", 32'(o_Cmd_Ready), 32'(1));
        i_Bus_Rst_L = 1'b1;
        settle_and_score("post_reset");

        // Write: CS exactly in the cycle after edge E+1
        push_cmd(1'b1, 8'h01, 8'h7B, 0, 8'h00, 1'b1, 1'b1);
        check("wr_cs_e", 32'(o_Bus_CS), 32'(0));
        check("wr_busy", 32'(o_Busy), 32'(1));
        @(negedge i_Bus_Clk);
        check("wr_cs_e1", 32'(o_Bus_CS), 32'(1));
        check("wr_bus", 32'({o_Bus_Wr_Rd_n, o_Bus_Addr8, o_Bus_Wr_Data}), 32'(17'h1017B));
        @(negedge i_Bus_Clk);
        check("wr_cs_e2", 32'(o_Bus_CS), 32'(0));
        check("wr_busy_done", 32'(o_Busy), 32'(0));
        settle_and_score("write");

        // Reads: prompt answer, silent responder with stray late DV, answer on last edge
        read_timed("rd_prompt", 8'h02, 1, 8'h55);
        read_timed("rd_timeout", 8'h03, int'(TIMEOUT) + 3, 8'hC3);
        read_timed("rd_last_edge", 8'h04, int'(TIMEOUT), 8'h9E);
        read_timed("rd_one_late", 8'h05, int'(TIMEOUT) + 1, 8'h3C);

        // Stall a read, then try to push six commands while nothing drains
        push_cmd(1'b0, 8'h10, 8'h00, 20, 8'hEE, 1'b1, 1'b1);
        repeat (3) @(negedge i_Bus_Clk);
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            wr = (k == 0) ? 1'b1 : 1'($urandom);
            push_cmd(wr, 8'h20 + 8'(k), 8'($urandom), int'($urandom_range(1, TIMEOUT + 1)),
                     8'($urandom), accepted < int'(FIFO_DEPTH), 1'b1);
            if (accepted < int'(FIFO_DEPTH)) accepted++;
        end
        check("stall_full", 32'(o_Cmd_Ready), 32'(accepted < int'(FIFO_DEPTH)));
        settle_and_score("stall");

        // Reset while waiting on a silent read with two commands queued behind it
        push_cmd(1'b0, 8'h30, 8'h00, 0, 8'h00, 1'b1, 1'b1);
        repeat (3) @(negedge i_Bus_Clk);
        push_cmd(1'b1, 8'h31, 8'h44, 0, 8'h00, 1'b1, 1'b0);
        push_cmd(1'b0, 8'h32, 8'h00, 2, 8'h66, 1'b1, 1'b0);
        i_Bus_Rst_L = 1'b0;
        @(negedge i_Bus_Clk);
        check("mid_rst_busy", 32'(o_Busy), 32'(0));
        check("mid_rst_ready", 32'(o_Cmd_Ready), 32'(1));
        check("mid_rst_outs", 32'({o_Bus_CS, o_Rsp_DV}), 32'(0));
        repeat (2) @(negedge i_Bus_Clk);
        exp_rsp.delete();
        plan_d.delete();
        plan_data.delete();
        due_map.delete();
        i_Bus_Rst_L = 1'b1;
        repeat (20) @(negedge i_Bus_Clk);
        settle_and_score("mid_reset");

        // Random bursts of up to FIFO_DEPTH commands into an idle master
        for (int b = 0; b < 25; b++) begin
            nb = int'($urandom_range(1, FIFO_DEPTH));
            for (int k = 0; k < nb; k++) begin
                rnd_d = 8'($urandom_range(0, TIMEOUT + 1));
                push_cmd(1'($urandom), 8'($urandom), 8'($urandom), int'(rnd_d), 8'($urandom),
                         1'b1, 1'b1);
            end
            settle_and_score("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
